// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-read-port register file: FSM encoding,
// address-width helper and data reset value.
package regfile_pkg;

  typedef enum logic {
    RF_CLEAR = 1'b0,
    RF_READY = 1'b1
  } rf_state_e;

  // Value replicated across XLEN when the clear sequencer zeroes an entry.
  localparam logic RF_DATA_RST_BIT = 1'b0;

  function automatic int rf_addr_width(input int num_regs);
    return (num_regs > 1) ? $clog2(num_regs) : 1;
  endfunction

endpackage

// File: rtl/reg_file_scoreboard.sv
// Pending-write scoreboard: one bit per register, set at issue and cleared at
// writeback, with set winning on a same-register collision.
module reg_file_scoreboard
  import regfile_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int NUM_RD   = 2,
  localparam int AW      = rf_addr_width(NUM_REGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             gate_en,
  input  logic             set_en,
  input  logic [AW-1:0]    set_addr,
  input  logic             clr_en,
  input  logic [AW-1:0]    clr_addr,
  input  logic [NUM_RD*AW-1:0] rd_addr,
  output logic [NUM_RD-1:0]    rd_pending
);

  logic [NUM_REGS-1:0] pend_q, pend_d;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    pend_d = pend_q;
    if (gate_en) begin
      if (clr_en) pend_d[clr_addr] = 1'b0;
      // Applied after the clear so a new producer supersedes the retiring one.
      if (set_en) pend_d[set_addr] = 1'b1;
    end
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) pend_q <= '0;
    else        pend_q <= pend_d;
  end

  always_comb begin
    rd_pending = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      rd_pending[k] = gate_en & pend_q[rd_addr[k*AW +: AW]];
    end
  end

endmodule

// File: rtl/reg_file_mp.sv
// Parametrised multi-read-port integer register file with post-reset clear
// sequencer and pending-write scoreboard. Optional macro REGFILE_WR_BYPASS_EN
// forwards same-cycle writeback data and pending-clear to the read ports.
module reg_file_mp
  import regfile_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32,
  parameter int NUM_RD   = 2,
  localparam int AW      = rf_addr_width(NUM_REGS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [AW-1:0]          wr_addr,
  input  logic [XLEN-1:0]        wr_data,
  input  logic [NUM_RD*AW-1:0]   rd_addr,
  output logic [NUM_RD*XLEN-1:0] rd_data,
  output logic [NUM_RD-1:0]      rd_pending,
  input  logic                   issue_en,
  input  logic [AW-1:0]          issue_addr,
  input  logic                   wb_clr_en,
  output logic                   init_done
);

  rf_state_e         state_q, state_d;
  logic [AW-1:0]     clr_idx_q, clr_idx_d;
  logic              init_done_q, init_done_d;
  logic              mem_we;
  logic [AW-1:0]     mem_waddr;
  logic [XLEN-1:0]   mem_wdata;
  logic [XLEN-1:0]   mem_q [NUM_REGS];
  logic              ready;
  logic [NUM_RD-1:0] sb_pending;

  assign ready     = (state_q == RF_READY);
  assign init_done = init_done_q;

  always_comb begin
    state_d     = state_q;
    clr_idx_d   = clr_idx_q;
    init_done_d = init_done_q;
    mem_we      = 1'b0;
    mem_waddr   = wr_addr;
    mem_wdata   = wr_data;
    case (state_q)
      RF_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_idx_q;
        mem_wdata = {XLEN{RF_DATA_RST_BIT}};
        clr_idx_d = clr_idx_q + AW'(1);
        if (clr_idx_q == AW'(NUM_REGS - 1)) begin
          state_d     = RF_READY;
          init_done_d = 1'b1;
        end
      end
      RF_READY: mem_we = wr_en && (wr_addr != '0);
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= RF_CLEAR;
      clr_idx_q   <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_idx_q   <= clr_idx_d;
      init_done_q <= init_done_d;
    end
  end

  // NOTE: the array has no reset branch; the CLEAR state zeroes it one entry per cycle.
  always_ff @(posedge clk) begin
    if (rst_n && mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  always_comb begin
    rd_data = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      if (ready && (rd_addr[k*AW +: AW] != '0)) begin
        rd_data[k*XLEN +: XLEN] = mem_q[rd_addr[k*AW +: AW]];
`ifdef REGFILE_WR_BYPASS_EN
        if (wr_en && (wr_addr == rd_addr[k*AW +: AW])) rd_data[k*XLEN +: XLEN] = wr_data;
`endif
      end
    end
  end

  reg_file_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .NUM_RD   (NUM_RD)
  ) u_scoreboard (
    .clk        (clk),
    .rst_n      (rst_n),
    .gate_en    (ready),
    .set_en     (issue_en),
    .set_addr   (issue_addr),
    .clr_en     (wb_clr_en),
    .clr_addr   (wr_addr),
    .rd_addr    (rd_addr),
    .rd_pending (sb_pending)
  );

  always_comb begin
    rd_pending = sb_pending;
`ifdef REGFILE_WR_BYPASS_EN
    // A retiring write hides the pending bit unless a new producer claims the same register.
    for (int k = 0; k < NUM_RD; k++) begin
      if (ready && wr_en && wb_clr_en && (wr_addr != '0) &&
          (wr_addr == rd_addr[k*AW +: AW]) &&
          !(issue_en && (issue_addr == wr_addr))) begin
        rd_pending[k] = 1'b0;
      end
    end
`endif
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed, table-driven bench for reg_file_mp: default 32x32 two-port
// instance plus a 16-entry three-port instance for the parameter sweep.
module tb_reg_file_mp;

`ifdef REGFILE_WR_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en, issue_en, wb_clr_en, init_done;
  logic [4:0]  wr_addr, issue_addr;
  logic [31:0] wr_data;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_pending;

  logic        s_wr_en, s_issue_en, s_wb_clr_en, s_init_done;
  logic [3:0]  s_wr_addr, s_issue_addr;
  logic [31:0] s_wr_data;
  logic [11:0] s_rd_addr;
  logic [95:0] s_rd_data;
  logic [2:0]  s_rd_pending;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  reg_file_mp u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_pending (rd_pending),
    .issue_en   (issue_en),
    .issue_addr (issue_addr),
    .wb_clr_en  (wb_clr_en),
    .init_done  (init_done)
  );

  reg_file_mp #(.XLEN(32), .NUM_REGS(16), .NUM_RD(3)) u_sweep (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (s_wr_en),
    .wr_addr    (s_wr_addr),
    .wr_data    (s_wr_data),
    .rd_addr    (s_rd_addr),
    .rd_data    (s_rd_data),
    .rd_pending (s_rd_pending),
    .issue_en   (s_issue_en),
    .issue_addr (s_issue_addr),
    .wb_clr_en  (s_wb_clr_en),
    .init_done  (s_init_done)
  );

  typedef struct {
    string       name;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        clr;
    logic        ie;
    logic [4:0]  ia;
    logic [4:0]  r0, r1;
    logic [31:0] e0, e1;
    logic [1:0]  ep;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input string n, input logic we, input logic [4:0] wa,
                              input logic [31:0] wd, input logic clr, input logic ie,
                              input logic [4:0] ia, input logic [4:0] r0, input logic [4:0] r1,
                              input logic [31:0] e0, input logic [31:0] e1, input logic [1:0] ep);
    vec_t v;
    v.name = n; v.we = we; v.wa = wa; v.wd = wd; v.clr = clr; v.ie = ie; v.ia = ia;
    v.r0 = r0; v.r1 = r1; v.e0 = e0; v.e1 = e1; v.ep = ep;
    return v;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_main();
    wr_en = 0; wr_addr = 0; wr_data = 0; issue_en = 0; issue_addr = 0; wb_clr_en = 0;
    rd_addr = 0;
  endtask

  task automatic idle_sweep();
    s_wr_en = 0; s_wr_addr = 0; s_wr_data = 0; s_issue_en = 0; s_issue_addr = 0;
    s_wb_clr_en = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    next_cycle();
    rst_n = 1'b1;
  endtask

  task automatic wait_init(output int n);
    n = 0;
    while (!init_done && n < 200) begin
      next_cycle();
      n++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0;
    idle_main();
    idle_sweep();
    s_rd_addr = {4'd2, 4'd1, 4'd1};
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 check("reset_init_done", init_done, 1'b0);
    check("reset_pending", rd_pending, 2'b00);
    rst_n = 1'b1;

    // Clear sequence; the sweep instance gets writes/issues that must be ignored.
    for (int i = 1; i <= 32; i++) begin
      if (i <= 16) begin
        s_wr_en = 1; s_wr_addr = 4'd1; s_wr_data = 32'hBAD0_BAD0;
        s_issue_en = 1; s_issue_addr = 4'd2;
      end else begin
        idle_sweep();
      end
      next_cycle();
      #1;
      check($sformatf("init_done_edge%0d", i), init_done, (i >= 32));
      check($sformatf("sw_init_done_edge%0d", i), s_init_done, (i >= 16));
      if (i <= 15) begin
        check($sformatf("sw_clear_rd_edge%0d", i), s_rd_data, 96'h0);
        check($sformatf("sw_clear_pend_edge%0d", i), s_rd_pending, 3'b000);
      end
    end

    check("sw_dropped_writes", s_rd_data, 96'h0);
    check("sw_dropped_issue", s_rd_pending, 3'b000);
    s_wr_en = 1; s_wr_addr = 4'd1;  s_wr_data = 32'h1111_0001;
    next_cycle();
    s_wr_addr = 4'd15; s_wr_data = 32'hF0F0_0015;
    next_cycle();
    idle_sweep();
    s_rd_addr = {4'd15, 4'd1, 4'd1};
    #1 check("sw_three_reads", s_rd_data, {32'hF0F0_0015, 32'h1111_0001, 32'h1111_0001});

    for (int a = 0; a < 32; a++) begin
      rd_addr = {5'(31 - a), 5'(a)};
      #1 check($sformatf("read_all_zero_%0d", a), rd_data, 64'h0);
    end

    vecs.push_back(mk("wr_x5",        1, 5, 32'hDEADBEEF, 0, 0, 0, 5, 0, BYP ? 32'hDEADBEEF : 32'h0, 0, 2'b00));
    vecs.push_back(mk("rd_x5_x0",     0, 0, 0,            0, 0, 0, 5, 0, 32'hDEADBEEF, 0, 2'b00));
    vecs.push_back(mk("wr_x0",        1, 0, 32'h12345678, 0, 0, 0, 0, 5, 0, 32'hDEADBEEF, 2'b00));
    vecs.push_back(mk("rd_x0_after",  0, 0, 0,            0, 0, 0, 0, 0, 0, 0, 2'b00));
    vecs.push_back(mk("wr_x7_old",    1, 7, 32'h11111111, 0, 0, 0, 5, 7, 32'hDEADBEEF, BYP ? 32'h11111111 : 32'h0, 2'b00));
    vecs.push_back(mk("wr_x7_byp",    1, 7, 32'hA5A5A5A5, 0, 0, 0, 7, 7, BYP ? 32'hA5A5A5A5 : 32'h11111111, BYP ? 32'hA5A5A5A5 : 32'h11111111, 2'b00));
    vecs.push_back(mk("rd_x7_new",    0, 0, 0,            0, 0, 0, 7, 5, 32'hA5A5A5A5, 32'hDEADBEEF, 2'b00));
    vecs.push_back(mk("issue_x3",     0, 0, 0,            0, 1, 3, 3, 3, 0, 0, 2'b00));
    vecs.push_back(mk("pend_x3",      0, 0, 0,            0, 0, 0, 3, 0, 0, 0, 2'b01));
    vecs.push_back(mk("set_clr_x3",   0, 3, 0,            1, 1, 3, 3, 3, 0, 0, 2'b11));
    vecs.push_back(mk("set_wins_x3",  0, 0, 0,            0, 0, 0, 3, 3, 0, 0, 2'b11));
    vecs.push_back(mk("clr_x3",       0, 3, 0,            1, 0, 0, 3, 3, 0, 0, 2'b11));
    vecs.push_back(mk("cleared_x3",   0, 0, 0,            0, 0, 0, 3, 3, 0, 0, 2'b00));
    vecs.push_back(mk("issue_x0",     0, 0, 0,            0, 1, 0, 0, 0, 0, 0, 2'b00));
    vecs.push_back(mk("x0_never",     0, 0, 0,            0, 0, 0, 0, 0, 0, 0, 2'b00));
    vecs.push_back(mk("issue_x3_b",   0, 0, 0,            0, 1, 3, 3, 4, 0, 0, 2'b00));
    vecs.push_back(mk("wb_x3_iss_x4", 1, 3, 32'h33,       1, 1, 4, 3, 4, BYP ? 32'h33 : 32'h0, 0, {1'b0, ~BYP}));
    vecs.push_back(mk("diff_regs",    0, 0, 0,            0, 0, 0, 3, 4, 32'h33, 0, 2'b10));
    vecs.push_back(mk("wb_iss_x4",    1, 4, 32'h44,       1, 1, 4, 4, 4, BYP ? 32'h44 : 32'h0, BYP ? 32'h44 : 32'h0, 2'b11));
    vecs.push_back(mk("x4_still",     0, 0, 0,            0, 0, 0, 4, 4, 32'h44, 32'h44, 2'b11));
    vecs.push_back(mk("wb_x4",        1, 4, 32'h45,       1, 0, 0, 4, 3, BYP ? 32'h45 : 32'h44, 32'h33, {1'b0, ~BYP}));
    vecs.push_back(mk("x4_done",      0, 0, 0,            0, 0, 0, 4, 3, 32'h45, 32'h33, 2'b00));

    foreach (vecs[i]) begin
      wr_en = vecs[i].we; wr_addr = vecs[i].wa; wr_data = vecs[i].wd;
      wb_clr_en = vecs[i].clr; issue_en = vecs[i].ie; issue_addr = vecs[i].ia;
      rd_addr = {vecs[i].r1, vecs[i].r0};
      #1;
      check({vecs[i].name, "_rd0"}, rd_data[31:0], vecs[i].e0);
      check({vecs[i].name, "_rd1"}, rd_data[63:32], vecs[i].e1);
      check({vecs[i].name, "_pend"}, rd_pending, vecs[i].ep);
      next_cycle();
    end
    idle_main();

    // Reset after real traffic: contents and scoreboard must come back clean.
    wr_en = 1; wr_addr = 9; wr_data = 32'h0000_0099; issue_en = 1; issue_addr = 9;
    next_cycle();
    idle_main();
    rd_addr = {5'd0, 5'd9};
    #1 check("x9_written", rd_data, {32'h0, 32'h0000_0099});
    check("x9_pending", rd_pending, 2'b01);
    reset_pulse();
    #1 check("reset_drops_init_done", init_done, 1'b0);
    wait_init(n);
    check("reinit_cycles", n, 32);
    for (int a = 0; a < 32; a++) begin
      rd_addr = {5'(a), 5'(a)};
      #1 check($sformatf("post_reset_zero_%0d", a), rd_data, 64'h0);
      check($sformatf("post_reset_pend_%0d", a), rd_pending, 2'b00);
    end

    // Reset in the middle of CLEAR restarts the sequence from index 0.
    reset_pulse();
    repeat (10) next_cycle();
    #1 check("mid_clear_not_done", init_done, 1'b0);
    reset_pulse();
    wait_init(n);
    check("mid_clear_restart_cycles", n, 32);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
